wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 4-stage RV32I pipeline. It registers the execute/memory results and aligns and sign-extends load data from the synchronous data memory. It selects the writeback value and drives the register file write port, suppressing writes to x0. It also presents the same value as a forwarding source to decode/execute and keeps the 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- ex_valid  in  1  instruction present in execute/memory stage
- ex_reg_wen  in  1  instruction writes rd
- ex_rd  in  5  destination register index
- ex_wb_sel  in  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU
- ex_alu_result  in  32  ALU result / load effective address
- ex_pc_plus4  in  32  link value for JAL/JALR
- ex_funct3  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- dmem_rdata  in  32  data memory read word, valid during the WB cycle
- stall  in  1  freeze WB stage
- flush  in  1  kill instruction entering WB
- wb_wen  out  1  register file write enable
- wb_rd  out  5  register file write index
- wb_data  out  32  register file write data
- fwd_valid  out  1  forwarding source valid (equals wb_wen)
- instret  out  64  retired-instruction count

## Operation
- Stage register fields: valid, reg_wen, rd, wb_sel, alu_result, pc_plus4, funct3.
- Capture on each rising edge:
  - flush=1: valid<=0 and other fields don't-care; flush has priority over stall.
  - stall=1 and flush=0: all fields hold.
  - otherwise: all fields load from the ex_* inputs.
- Load alignment uses byte offset addr_lo = alu_result[1:0] of the registered instruction.
  - LB/LBU: byte dmem_rdata[8*addr_lo +: 8], sign- or zero-extended.
  - LH/LHU: halfword chosen by addr_lo[1] (0 → bits 15:0, 1 → bits 31:16), sign- or zero-extended; addr_lo[0] is ignored, with no misaligned trap.
  - LW, and funct3 011/110/111: full word, and addr_lo is ignored.
- wb_data is combinational from the registered fields and dmem_rdata:
  - wb_sel 01: the aligned load value.
  - wb_sel 10: pc_plus4.
  - otherwise: alu_result.
- wb_rd = registered rd.
- wb_wen = valid & reg_wen & (rd != 0) & ~stall. An x0 write is never issued.
- Retirement: an instruction retires on an edge where valid=1 and stall=0, whether or not it writes rd; instret increments by 1.
- instret is 64-bit unsigned and wraps from 2^64-1 to 0.

## Timing
- Reset (rst low, asynchronous): valid=0, instret=0, wb_wen=0, fwd_valid=0, wb_rd=0, wb_data=0. All registered fields are cleared.
- Reset deassertion is sampled synchronously; the first capture happens on the first edge with rst high.
- Latency:
  - An instruction presented on ex_* at edge N drives wb_* in cycle N..N+1.
  - The register file commits it at edge N+1.
  - instret shows the increment after edge N+1.
- Stall: wb_wen=0 for the whole stall; the held instruction writes exactly once, in the first unstalled cycle.
- Flush and stall together: the flush wins. Valid clears at the edge, so a held WB instruction is discarded without retiring.
- Reset mid-operation: the in-flight instruction is dropped with no write and no count.
- Back-to-back instructions with no stall: one write and one retirement per cycle.

## Test plan
- Reset, then ALU op with rd=5 and alu_result=0x1234_5678 → next cycle wb_wen=1, wb_rd=5, wb_data=0x1234_5678; instret=1 after the following edge.
- Loads with dmem_rdata=0x80F1_7F82:
  - LB, addr_lo=0 → 0xFFFF_FF82
  - LBU, addr_lo=3 → 0x0000_0080
  - LH, addr_lo=2 → 0xFFFF_80F1
  - LHU, addr_lo=0 → 0x0000_7F82
  - LW → 0x80F1_7F82
- JAL with rd=1, pc_plus4=0x0000_0104, wb_sel=10 → wb_data=0x104, wb_wen=1. The same instruction with rd=0 → wb_wen=0, but instret still increments.
- Instruction in WB, then stall held 3 cycles → wb_wen=0 for 3 cycles, then a single 1-cycle write; instret increases by exactly 1.
- flush asserted with ex_valid=1, including a cycle where stall is also 1 → no write and no count. Separately, assert rst mid-stream → instret=0 and wb_wen=0 immediately, without waiting for a clock edge.
- Preload instret to 2^64-2 via back-door force, then retire 3 instructions → count goes 2^64-1, 0, 1.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage of the 4-stage RV32I pipeline: registers the execute/memory result,
// aligns load data, drives the register file write port and keeps the retired count.
module wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_reg_wen,
  input  logic [4:0]      ex_rd,
  input  logic [1:0]      ex_wb_sel,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            stall,
  input  logic            flush,
  output logic            wb_wen,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            fwd_valid,
  output logic [63:0]     instret
);

  logic            r_valid;
  logic            r_reg_wen;
  logic [4:0]      r_rd;
  logic [1:0]      r_wb_sel;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_pc_plus4;
  logic [2:0]      r_funct3;
  logic [63:0]     r_instret;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic            w_retire;

  // stall and flush are level controls sampled at every rising edge; flush beats stall,
  // and the instruction already in WB retires on any edge where it is valid and unstalled.
  assign w_retire = r_valid & ~stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_reg_wen    <= 1'b0;
      r_rd         <= '0;
      r_wb_sel     <= '0;
      r_alu_result <= '0;
      r_pc_plus4   <= '0;
      r_funct3     <= '0;
      r_instret    <= '0;
    end else begin
      if (w_retire) r_instret <= r_instret + 64'd1;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (!stall) begin
        r_valid      <= ex_valid;
        r_reg_wen    <= ex_reg_wen;
        r_rd         <= ex_rd;
        r_wb_sel     <= ex_wb_sel;
        r_alu_result <= ex_alu_result;
        r_pc_plus4   <= ex_pc_plus4;
        r_funct3     <= ex_funct3;
      end
    end
  end

  // Halfword selection ignores addr[0]: misaligned halves are not trapped here.
  assign w_byte = dmem_rdata[{r_alu_result[1:0], 3'b000} +: 8];
  assign w_half = r_alu_result[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_load = dmem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_comb begin
    wb_data = r_alu_result;
    case (r_wb_sel)
      2'b01:   wb_data = w_load;
      2'b10:   wb_data = r_pc_plus4;
      default: wb_data = r_alu_result;
    endcase
  end

  assign wb_rd     = r_rd;
  assign wb_wen    = r_valid & r_reg_wen & (r_rd != 5'd0) & ~stall;
  assign fwd_valid = wb_wen;
  assign instret   = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed instruction vectors, a behavioural WB model checked
// every cycle, and literal expectations for the load/link/counter cases.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_reg_wen;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_wb_sel;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_pc_plus4;
  logic [2:0]  ex_funct3;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        flush;
  logic        wb_wen;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        fwd_valid;
  logic [63:0] instret;

  int tests = 0;
  int fails = 0;

  wb_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_reg_wen(ex_reg_wen), .ex_rd(ex_rd),
    .ex_wb_sel(ex_wb_sel), .ex_alu_result(ex_alu_result), .ex_pc_plus4(ex_pc_plus4),
    .ex_funct3(ex_funct3), .dmem_rdata(dmem_rdata), .stall(stall), .flush(flush),
    .wb_wen(wb_wen), .wb_rd(wb_rd), .wb_data(wb_data), .fwd_valid(fwd_valid),
    .instret(instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // behavioural model: the instruction currently held in WB plus the retire count
  typedef struct {
    logic        v;
    logic        wen;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [2:0]  f3;
  } instr_t;

  instr_t      m_wb;
  logic [63:0] exp_instret;

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    int unsigned sh_b, sh_h;
    logic [31:0] b, h;
    sh_b = 8 * int'(addr[1:0]);
    sh_h = addr[1] ? 16 : 0;
    b = (word >> sh_b) & 32'hFF;
    h = (word >> sh_h) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
      3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wb        = '{v: 1'b0, wen: 1'b0, rd: 5'd0, sel: 2'd0, alu: 32'd0, pc: 32'd0, f3: 3'd0};
      exp_instret = 64'd0;
    end else begin
      if (m_wb.v && !stall) exp_instret = exp_instret + 64'd1;
      if (flush) m_wb.v = 1'b0;
      else if (!stall)
        m_wb = '{v: ex_valid, wen: ex_reg_wen, rd: ex_rd, sel: ex_wb_sel,
                 alu: ex_alu_result, pc: ex_pc_plus4, f3: ex_funct3};
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic        e_wen;
    logic [31:0] e_data;
    if (rst) begin
      e_wen  = m_wb.v && m_wb.wen && (m_wb.rd != 0) && !stall;
      e_data = (m_wb.sel == 2'b01) ? load_value(m_wb.f3, m_wb.alu, dmem_rdata) :
               (m_wb.sel == 2'b10) ? m_wb.pc : m_wb.alu;
      check("model_wen", {63'd0, wb_wen}, {63'd0, e_wen});
      check("model_fwd", {63'd0, fwd_valid}, {63'd0, e_wen});
      check("model_instret", instret, exp_instret);
      if (m_wb.v) begin
        check("model_rd", {59'd0, wb_rd}, {59'd0, m_wb.rd});
        check("model_data", {32'd0, wb_data}, {32'd0, e_data});
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                         input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    ex_valid = 1'b1; ex_reg_wen = wen; ex_rd = rd; ex_wb_sel = sel;
    ex_alu_result = alu; ex_pc_plus4 = pc; ex_funct3 = f3;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_reg_wen = 1'b0; ex_rd = 5'd0; ex_wb_sel = 2'd0;
    ex_alu_result = 32'd0; ex_pc_plus4 = 32'd0; ex_funct3 = 3'd0;
  endtask

  // leaves the instruction in WB, just after the capturing edge
  task automatic issue(input logic wen, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    present(wen, rd, sel, alu, pc, f3);
    step();
    idle();
  endtask

  logic [63:0] base;

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'd0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset_wen", {63'd0, wb_wen}, 64'd0);
    check("reset_fwd", {63'd0, fwd_valid}, 64'd0);
    check("reset_rd", {59'd0, wb_rd}, 64'd0);
    check("reset_data", {32'd0, wb_data}, 64'd0);
    check("reset_instret", instret, 64'd0);
    rst = 1'b1;

    // ALU writeback
    issue(1'b1, 5'd5, 2'b00, 32'h1234_5678, 32'h0, 3'b000);
    @(negedge clk);
    check("alu_wen", {63'd0, wb_wen}, 64'd1);
    check("alu_rd", {59'd0, wb_rd}, 64'd5);
    check("alu_data", {32'd0, wb_data}, 64'h1234_5678);
    check("alu_instret_pre", instret, 64'd0);
    step();
    check("alu_instret_post", instret, 64'd1);

    // loads
    dmem_rdata = 32'h80F1_7F82;
    issue(1'b1, 5'd10, 2'b01, 32'h0000_0100, 32'h0, 3'b000);
    @(negedge clk); check("lb_off0", {32'd0, wb_data}, 64'hFFFF_FF82);
    issue(1'b1, 5'd11, 2'b01, 32'h0000_0103, 32'h0, 3'b100);
    @(negedge clk); check("lbu_off3", {32'd0, wb_data}, 64'h0000_0080);
    issue(1'b1, 5'd12, 2'b01, 32'h0000_0102, 32'h0, 3'b001);
    @(negedge clk); check("lh_off2", {32'd0, wb_data}, 64'hFFFF_80F1);
    issue(1'b1, 5'd13, 2'b01, 32'h0000_0100, 32'h0, 3'b101);
    @(negedge clk); check("lhu_off0", {32'd0, wb_data}, 64'h0000_7F82);
    issue(1'b1, 5'd14, 2'b01, 32'h0000_0101, 32'h0, 3'b010);
    @(negedge clk); check("lw", {32'd0, wb_data}, 64'h80F1_7F82);
    issue(1'b1, 5'd15, 2'b01, 32'h0000_0103, 32'h0, 3'b110);
    @(negedge clk); check("ld_f3_110", {32'd0, wb_data}, 64'h80F1_7F82);
    issue(1'b1, 5'd16, 2'b01, 32'h0000_0101, 32'h0, 3'b000);
    @(negedge clk); check("lb_off1", {32'd0, wb_data}, 64'h0000_007F);
    issue(1'b1, 5'd17, 2'b11, 32'hCAFE_0001, 32'h44, 3'b000);
    @(negedge clk); check("sel11_alu", {32'd0, wb_data}, 64'hCAFE_0001);

    // link value, then x0 destination still retires
    issue(1'b1, 5'd1, 2'b10, 32'h0000_0200, 32'h0000_0104, 3'b000);
    @(negedge clk);
    check("jal_data", {32'd0, wb_data}, 64'h104);
    check("jal_wen", {63'd0, wb_wen}, 64'd1);
    base = instret;
    issue(1'b1, 5'd0, 2'b10, 32'h0000_0200, 32'h0000_0104, 3'b000);
    @(negedge clk);
    check("x0_wen", {63'd0, wb_wen}, 64'd0);
    step();
    check("x0_retire", instret, base + 64'd2);

    // stall held 3 cycles, then one write and one retirement
    issue(1'b1, 5'd7, 2'b00, 32'h0000_0777, 32'h0, 3'b000);
    stall = 1'b1;
    base = instret;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_wen", {63'd0, wb_wen}, 64'd0);
      step();
    end
    stall = 1'b0;
    @(negedge clk);
    check("unstall_wen", {63'd0, wb_wen}, 64'd1);
    check("unstall_data", {32'd0, wb_data}, 64'h777);
    check("stall_no_count", instret, base);
    step();
    check("stall_one_count", instret, base + 64'd1);
    @(negedge clk);
    check("after_stall_wen", {63'd0, wb_wen}, 64'd0);

    // flush of an entering instruction, then flush+stall on a held one
    base = instret;
    present(1'b1, 5'd8, 2'b00, 32'h88, 32'h0, 3'b000);
    flush = 1'b1;
    step();
    flush = 1'b0; idle();
    @(negedge clk);
    check("flush_wen", {63'd0, wb_wen}, 64'd0);
    issue(1'b1, 5'd9, 2'b00, 32'h99, 32'h0, 3'b000);
    stall = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_stall_wen", {63'd0, wb_wen}, 64'd0);
    step();
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_stall_wen2", {63'd0, wb_wen}, 64'd0);
    step();
    check("flush_no_count", instret, base);

    // asynchronous reset mid-stream
    issue(1'b1, 5'd3, 2'b00, 32'h33, 32'h0, 3'b000);
    #2;
    rst = 1'b0;
    #1;
    check("arst_instret", instret, 64'd0);
    check("arst_wen", {63'd0, wb_wen}, 64'd0);
    check("arst_fwd", {63'd0, fwd_valid}, 64'd0);
    step();
    rst = 1'b1;
    @(negedge clk);
    check("arst_hold", instret, 64'd0);

    // counter wrap from a back-door preload
    step();
    force dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.r_instret;
    #1;
    check("preload", instret, 64'hFFFF_FFFF_FFFF_FFFE);
    present(1'b1, 5'd20, 2'b00, 32'h1, 32'h0, 3'b000); step();
    present(1'b1, 5'd21, 2'b00, 32'h2, 32'h0, 3'b000); step();
    check("wrap_ff", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    present(1'b1, 5'd22, 2'b00, 32'h3, 32'h0, 3'b000); step();
    check("wrap_0", instret, 64'd0);
    idle(); step();
    check("wrap_1", instret, 64'd1);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
